// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - ALU command codes, shift types, NZCV bit positions and a rotate helper
package arm_pkg;

    localparam logic [3:0] EXEC_NOP = 4'b0000;
    localparam logic [3:0] EXEC_MOV = 4'b0001;
    localparam logic [3:0] EXEC_ADD = 4'b0010;
    localparam logic [3:0] EXEC_ADC = 4'b0011;
    localparam logic [3:0] EXEC_SUB = 4'b0100;
    localparam logic [3:0] EXEC_SBC = 4'b0101;
    localparam logic [3:0] EXEC_AND = 4'b0110;
    localparam logic [3:0] EXEC_ORR = 4'b0111;
    localparam logic [3:0] EXEC_EOR = 4'b1000;
    localparam logic [3:0] EXEC_MVN = 4'b1001;

    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // A left shift by 32 yields zero, so r=0 degenerates cleanly to x.
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// rtl/exe_stage_val2_gen.sv - combinational shifter operand (Val2) generator
module val2_gen
    import arm_pkg::*;
(
    input  logic        imm,
    input  logic        mem_en,
    input  logic [11:0] shift_op,
    input  logic [31:0] val_rm,
    output logic [31:0] val2
);

    always_comb begin
        val2 = val_rm;
        if (imm) begin
            val2 = ror32({24'd0, shift_op[7:0]}, {shift_op[11:8], 1'b0});
        end else if (mem_en) begin
            val2 = {20'd0, shift_op};
        end else begin
            case (shift_op[6:5])
                SHIFT_LSL: val2 = val_rm << shift_op[11:7];
                SHIFT_LSR: val2 = val_rm >> shift_op[11:7];
                SHIFT_ASR: val2 = $unsigned($signed(val_rm) >>> shift_op[11:7]);
                default:   val2 = ror32(val_rm, shift_op[11:7]);
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM execute stage: Val2, ALU, NZCV register, EX/MEM register (option: FORWARDING_EN)
module exe_stage
    import arm_pkg::*;
#(
    parameter int         DATA_W     = 32,
    parameter logic [3:0] STATUS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
`ifdef FORWARDING_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] fwd_mem_val,
    input  logic [DATA_W-1:0] fwd_wb_val,
`endif
    input  logic [3:0]        exec_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              s_in,
    input  logic              b_in,
    input  logic              imm_in,
    input  logic [3:0]        dest_in,
    input  logic [11:0]       shift_op_in,
    input  logic [23:0]       simm24_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        status,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        dest_out,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out
);

    logic [DATA_W-1:0] rn, rm, val2, op_b, res;
    logic [DATA_W:0]   sum;
    logic              c_new, v_new, arith, known;

`ifdef FORWARDING_EN
    always_comb begin
        case (sel_src1)
            2'b01:   rn = fwd_mem_val;
            2'b10:   rn = fwd_wb_val;
            default: rn = val_rn_in;
        endcase
        case (sel_src2)
            2'b01:   rm = fwd_mem_val;
            2'b10:   rm = fwd_wb_val;
            default: rm = val_rm_in;
        endcase
    end
`else
    assign rn = val_rn_in;
    assign rm = val_rm_in;
`endif

    val2_gen u_val2_gen (
        .imm      (imm_in),
        .mem_en   (mem_r_en_in | mem_w_en_in),
        .shift_op (shift_op_in),
        .val_rm   (rm),
        .val2     (val2)
    );

    // Subtraction is rn + ~val2 + carry_in so C naturally means "no borrow".
    always_comb begin
        sum   = '0;
        res   = '0;
        op_b  = val2;
        arith = 1'b0;
        known = 1'b1;
        case (exec_cmd_in)
            EXEC_MOV: res = val2;
            EXEC_MVN: res = ~val2;
            EXEC_AND: res = rn & val2;
            EXEC_ORR: res = rn | val2;
            EXEC_EOR: res = rn ^ val2;
            EXEC_ADD: begin arith = 1'b1; sum = {1'b0, rn} + {1'b0, val2}; end
            EXEC_ADC: begin arith = 1'b1; sum = {1'b0, rn} + {1'b0, val2} + {{DATA_W{1'b0}}, status[FLAG_C]}; end
            EXEC_SUB: begin arith = 1'b1; op_b = ~val2; sum = {1'b0, rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1}; end
            EXEC_SBC: begin arith = 1'b1; op_b = ~val2; sum = {1'b0, rn} + {1'b0, ~val2} + {{DATA_W{1'b0}}, status[FLAG_C]}; end
            default:  known = 1'b0;
        endcase
        if (arith) res = sum[DATA_W-1:0];
        c_new = arith ? sum[DATA_W] : status[FLAG_C];
        v_new = arith ? ((rn[DATA_W-1] == op_b[DATA_W-1]) && (res[DATA_W-1] != rn[DATA_W-1]))
                      : status[FLAG_V];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= STATUS_RST;
        end else if (!freeze && s_in && known) begin
            status <= {res[DATA_W-1], (res == '0), c_new, v_new};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_out  <= '0;
            val_rm_out   <= '0;
            dest_out     <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
        end else if (!freeze) begin
            alu_res_out  <= res;
            val_rm_out   <= rm;
            dest_out     <= dest_in;
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
        end
    end

    assign branch_taken = b_in & ~freeze;
    assign branch_addr  = pc_in + {{(DATA_W-26){simm24_in[23]}}, simm24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - vector table, corner sequences and randomized reference-model check of exe_stage
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst_n, freeze;
    logic [3:0]  exec_cmd_in, dest_in;
    logic        mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in, imm_in;
    logic [11:0] shift_op_in;
    logic [23:0] simm24_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic [31:0] alu_res_out, val_rm_out;
    logic [3:0]  dest_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out;
`ifdef FORWARDING_EN
    logic [1:0]  sel_src1 = 2'b00, sel_src2 = 2'b00;
    logic [31:0] fwd_mem_val = 32'd0, fwd_wb_val = 32'd0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .freeze       (freeze),
`ifdef FORWARDING_EN
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .fwd_mem_val  (fwd_mem_val),
        .fwd_wb_val   (fwd_wb_val),
`endif
        .exec_cmd_in  (exec_cmd_in),
        .mem_r_en_in  (mem_r_en_in),
        .mem_w_en_in  (mem_w_en_in),
        .wb_en_in     (wb_en_in),
        .s_in         (s_in),
        .b_in         (b_in),
        .imm_in       (imm_in),
        .dest_in      (dest_in),
        .shift_op_in  (shift_op_in),
        .simm24_in    (simm24_in),
        .pc_in        (pc_in),
        .val_rn_in    (val_rn_in),
        .val_rm_in    (val_rm_in),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .status       (status),
        .alu_res_out  (alu_res_out),
        .val_rm_out   (val_rm_out),
        .dest_out     (dest_out),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .mem_w_en_out (mem_w_en_out)
    );

    typedef struct {
        logic [3:0]  cmd;
        bit          mr, mw, wb, s, imm;
        logic [3:0]  dest;
        logic [11:0] sop;
        logic [31:0] rn, rm, exp_res;
        logic [3:0]  exp_nzcv;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cmd, input bit mr, input bit mw, input bit wb, input bit s,
                         input bit imm, input logic [3:0] dest, input logic [11:0] sop,
                         input logic [31:0] rn, input logic [31:0] rm);
        exec_cmd_in = cmd; mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb; s_in = s;
        imm_in = imm; dest_in = dest; shift_op_in = sop; val_rn_in = rn; val_rm_in = rm;
    endtask

    // Reference Val2 from the operand rules, using bit-at-a-time rotation and 64-bit arithmetic.
    function automatic logic [31:0] m_val2(bit imm, bit mem, logic [11:0] sop, logic [31:0] rm);
        logic [31:0] x;
        longint      sx;
        int          n;
        if (imm) begin
            x = {24'd0, sop[7:0]};
            n = 2 * int'(sop[11:8]);
            repeat (n) x = (x >> 1) | ((x & 32'd1) << 31);
            return x;
        end
        if (mem) return {20'd0, sop};
        n = int'(sop[11:7]);
        case (sop[6:5])
            2'd0: return rm << n;
            2'd1: return rm >> n;
            2'd2: begin sx = $signed(rm); sx = sx >>> n; return sx[31:0]; end
            default: begin x = rm; repeat (n) x = (x >> 1) | ((x & 32'd1) << 31); return x; end
        endcase
    endfunction

    // Reference ALU: carries and overflow from wide unsigned/signed arithmetic.
    function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                                  input logic [3:0] f, output logic [31:0] res,
                                  output logic [3:0] nf, output bit known);
        longint ua, ub, us, sa, sb, ss, cin;
        bit     ar, c, v;
        ua = rn; ub = v2; sa = $signed(rn); sb = $signed(v2); cin = f[1];
        ar = 1'b0; known = 1'b1; res = 32'd0; us = 0; ss = 0;
        case (cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            4'd2: begin ar = 1; us = ua + ub;       ss = sa + sb;       end
            4'd3: begin ar = 1; us = ua + ub + cin; ss = sa + sb + cin; end
            4'd4: begin ar = 1; us = ua - ub;       ss = sa - sb;       end
            4'd5: begin ar = 1; us = ua - ub - (1 - cin); ss = sa - sb - (1 - cin); end
            default: known = 1'b0;
        endcase
        c = f[1]; v = f[0];
        if (ar) begin
            res = us[31:0];
            c   = (cmd == 4'd2 || cmd == 4'd3) ? (us >= 64'h1_0000_0000) : (us >= 0);
            v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        nf = {res[31], res == 32'd0, c, v};
    endfunction

    logic [31:0] m_res, m_rm, exp_addr, r_res;
    logic [3:0]  m_status, m_dest, r_nf;
    logic [2:0]  m_ctrl;
    bit          r_known;

    initial begin
        vt[0]  = '{4'h2, 0, 0, 1, 1, 1, 4'h1, 12'h00A, 32'h5,        32'h0,        32'd15,       4'h0};
        vt[1]  = '{4'h4, 0, 0, 1, 1, 0, 4'h2, 12'h000, 32'h3,        32'h3,        32'h0,        4'h6};
        vt[2]  = '{4'h3, 0, 0, 1, 0, 0, 4'h3, 12'h000, 32'h1,        32'h1,        32'h3,        4'h6};
        vt[3]  = '{4'h2, 0, 0, 1, 1, 0, 4'h4, 12'h000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'h9};
        vt[4]  = '{4'h1, 0, 0, 1, 0, 1, 4'h5, 12'h2FF, 32'h0,        32'h0,        32'hF000000F, 4'h9};
        vt[5]  = '{4'h1, 0, 0, 1, 1, 0, 4'h6, 12'h240, 32'h0,        32'h80000000, 32'hF8000000, 4'h9};
        vt[6]  = '{4'h4, 0, 0, 1, 1, 0, 4'h7, 12'h000, 32'h1,        32'h2,        32'hFFFFFFFF, 4'h8};
        vt[7]  = '{4'h5, 0, 0, 1, 1, 0, 4'h8, 12'h000, 32'hA,        32'h3,        32'h6,        4'h2};
        vt[8]  = '{4'h6, 0, 0, 1, 1, 0, 4'h9, 12'h000, 32'hF0,       32'h0F,       32'h0,        4'h6};
        vt[9]  = '{4'h7, 0, 0, 1, 0, 0, 4'hA, 12'h200, 32'hF0,       32'h1,        32'hF0,       4'h6};
        vt[10] = '{4'h8, 0, 0, 1, 1, 0, 4'hB, 12'hFA0, 32'hFF,       32'h80000000, 32'hFE,       4'h2};
        vt[11] = '{4'h9, 0, 0, 1, 1, 1, 4'hC, 12'h000, 32'h0,        32'h0,        32'hFFFFFFFF, 4'hA};
        vt[12] = '{4'h2, 1, 0, 1, 0, 0, 4'hD, 12'hFFF, 32'h1000,     32'h0,        32'h1FFF,     4'hA};
        vt[13] = '{4'h2, 0, 1, 0, 0, 0, 4'h0, 12'h004, 32'h2000,     32'hDEADBEEF, 32'h2004,     4'hA};
        vt[14] = '{4'hF, 0, 0, 1, 1, 0, 4'hE, 12'h000, 32'h5,        32'h5,        32'h0,        4'hA};
        vt[15] = '{4'h0, 0, 0, 0, 0, 0, 4'h0, 12'h000, 32'h0,        32'h0,        32'h0,        4'hA};
        vt[16] = '{4'h1, 0, 0, 1, 0, 0, 4'hF, 12'h460, 32'h0,        32'h12345678, 32'h78123456, 4'hA};
        vt[17] = '{4'h2, 0, 0, 1, 1, 0, 4'h1, 12'h000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'h6};

        rst_n = 1'b0; freeze = 1'b0; b_in = 1'b0; simm24_in = 24'd0; pc_in = 32'd0;
        drive(4'h2, 1, 1, 1, 1, 0, 4'h5, 12'h0, 32'h11, 32'h22);
        #3;
        chk("reset_status", {28'd0, status}, 32'd0);
        chk("reset_res", alu_res_out, 32'd0);
        chk("reset_ctrl", {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].cmd, vt[i].mr, vt[i].mw, vt[i].wb, vt[i].s, vt[i].imm,
                  vt[i].dest, vt[i].sop, vt[i].rn, vt[i].rm);
            step();
            chk($sformatf("vec%0d_res", i), alu_res_out, vt[i].exp_res);
            chk($sformatf("vec%0d_nzcv", i), {28'd0, status}, {28'd0, vt[i].exp_nzcv});
            chk($sformatf("vec%0d_dest", i), {28'd0, dest_out}, {28'd0, vt[i].dest});
            chk($sformatf("vec%0d_ctrl", i), {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out},
                {29'd0, vt[i].wb, vt[i].mr, vt[i].mw});
            chk($sformatf("vec%0d_rm", i), val_rm_out, vt[i].rm);
        end

        b_in = 1'b1; pc_in = 32'h100; simm24_in = 24'hFFFFFE; #1;
        chk("br_taken", {31'd0, branch_taken}, 32'd1);
        chk("br_addr", branch_addr, 32'hF8);
        freeze = 1'b1; #1;
        chk("br_taken_frozen", {31'd0, branch_taken}, 32'd0);
        freeze = 1'b0; b_in = 1'b0;

        // S-ADD lands, then three frozen cycles with different inputs must not disturb anything.
        drive(4'h2, 0, 0, 1, 1, 1, 4'h3, 12'h005, 32'hA, 32'h77);
        step();
        chk("frz_pre_res", alu_res_out, 32'd15);
        chk("frz_pre_nzcv", {28'd0, status}, 32'd0);
        freeze = 1'b1;
        drive(4'h4, 1, 0, 0, 1, 0, 4'h9, 12'h000, 32'h0, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("frz%0d_res", k), alu_res_out, 32'd15);
            chk($sformatf("frz%0d_nzcv", k), {28'd0, status}, 32'd0);
            chk($sformatf("frz%0d_dest", k), {28'd0, dest_out}, 32'd3);
            chk($sformatf("frz%0d_ctrl", k), {29'd0, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd4);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_frz_res", alu_res_out, 32'd0);
        chk("rst_frz_rm", val_rm_out, 32'd0);
        chk("rst_frz_ctrl", {25'd0, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out}, 32'd0);
        chk("rst_frz_nzcv", {28'd0, status}, 32'd0);
        @(negedge clk); rst_n = 1'b1; freeze = 1'b0;

        m_status = 4'd0; m_res = 32'd0; m_rm = 32'd0; m_dest = 4'd0; m_ctrl = 3'd0;
        for (int t = 0; t < 400; t++) begin
            logic [3:0]  cmd;
            logic [31:0] rn, rm, v2;
            logic [11:0] sop;
            bit          mr, mw, imm, s, wb, fr;
            cmd = 4'($urandom_range(0, 15));
            mr = ($urandom_range(0, 7) == 0); mw = !mr && ($urandom_range(0, 7) == 0);
            if (mr || mw) cmd = 4'h2;
            imm = $urandom_range(0, 1); s = $urandom_range(0, 1); wb = $urandom_range(0, 1);
            fr = ($urandom_range(0, 7) == 0);
            sop = 12'($urandom); rn = $urandom; rm = $urandom;
            if ($urandom_range(0, 5) == 0) rn = 32'h7FFFFFFF;
            if ($urandom_range(0, 5) == 0) rm = rn;
            drive(cmd, mr, mw, wb, s, imm, 4'($urandom), sop, rn, rm);
            freeze = fr; b_in = $urandom_range(0, 1); pc_in = $urandom; simm24_in = 24'($urandom);
            #1;
            exp_addr = pc_in + 32'(4 * ((int'(simm24_in) >= 8388608) ? int'(simm24_in) - 16777216
                                                                         : int'(simm24_in)));
            chk("rnd_br_taken", {31'd0, branch_taken}, {31'd0, b_in && !fr});
            chk("rnd_br_addr", branch_addr, exp_addr);
            v2 = m_val2(imm, mr || mw, sop, rm);
            m_alu(cmd, rn, v2, m_status, r_res, r_nf, r_known);
            if (!fr) begin
                if (s && r_known) m_status = r_nf;
                m_res = r_res; m_rm = rm; m_dest = dest_in; m_ctrl = {wb, mr, mw};
            end
            step();
            chk($sformatf("rnd%0d_res", t), alu_res_out, m_res);
            chk($sformatf("rnd%0d_nzcv", t), {28'd0, status}, {28'd0, m_status});
            chk($sformatf("rnd%0d_rm", t), val_rm_out, m_rm);
            chk($sformatf("rnd%0d_ctl", t), {25'd0, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out},
                {25'd0, m_dest, m_ctrl});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
